dvs_window_controller: RTL and testbench
========================================

# dvs_window_controller

Parametrised event-windowing front end for the DVS gesture pipeline. It sits between the DVS event source and the centre-of-mass accumulator. It generalises the fixed "trigger every N events" counter into a runtime-configured window with four modes: event-count, timestamp-span, either-first, or disabled. It adds a polarity filter, a ready/valid input handshake, registered event forwarding, and per-window statistics reported with each compute trigger.

## Interface
- X_BITS, 7, event x-coordinate width
- Y_BITS, 7, event y-coordinate width
- TS_BITS, 16, timestamp width; timestamps wrap modulo 2^TS_BITS
- CNT_BITS, 16, event-count and threshold width
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- cfg_mode  in  2  0=count, 1=time, 2=count-or-time (first to hit), 3=disabled (forward only)
- cfg_window_events  in  CNT_BITS  count threshold; 0 treated as 1
- cfg_window_ts  in  TS_BITS  span threshold in timestamp ticks
- cfg_pol_mask  in  2  bit0 accepts OFF events, bit1 accepts ON events
- event_valid  in  1  input event present
- event_ready  out  1  input handshake; an event transfers when valid & ready
- event_x / event_y  in  X_BITS / Y_BITS  event coordinates
- event_polarity  in  1  1=ON, 0=OFF
- event_ts  in  TS_BITS  event timestamp
- out_ready  in  1  downstream throttle
- out_valid  out  1  forwarded-event strobe
- out_x / out_y / out_polarity / out_ts  out  as inputs  forwarded event fields
- compute_trigger  out  1  one-cycle window-close pulse
- window_count  out  CNT_BITS  events in the closed window
- window_span  out  TS_BITS  last_ts − start_ts of the closed window, mod 2^TS_BITS
- window_cause  out  2  bit0=count threshold, bit1=time threshold

## Operation
- States: IDLE (no window open), OPEN, CLOSE.
- event_ready = out_ready & (state != CLOSE) & !rst. It is combinational.
- Accepted event means a transfer occurred. Counted event means an accepted event with cfg_pol_mask[event_polarity]=1.
- Masked (uncounted) events:
  - are consumed;
  - are not forwarded;
  - do not affect count or timestamps.
- Every counted event is forwarded, in every mode.
- IDLE:
  - A counted event (mode≠3) loads start_ts=last_ts=event_ts and count=1, then goes to OPEN.
  - The close test is applied to this same event.
- OPEN: each counted event does count+1 and last_ts=event_ts, then the close test is applied.
- Close test, evaluated on each counted event (the closing event belongs to the closing window):
  - count_hit = count_new ≥ max(cfg_window_events,1), in modes 0 and 2;
  - time_hit = (event_ts − start_ts) mod 2^TS_BITS ≥ cfg_window_ts, in modes 1 and 2;
  - in mode 1, count reaching all-ones forces count_hit (saturation guard).
- If either hit is true: go to CLOSE, latch window_cause={time_hit,count_hit}, latch window_count and window_span.
- CLOSE: lasts exactly one cycle. compute_trigger=1, then go to IDLE.
- The statistics outputs hold until the next close.
- Mode 3: state forced to IDLE, count held at 0, no triggers, forwarding continues.
- Configuration is read live at each evaluation. Changing it mid-window is legal and takes effect on the next counted event.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE, count 0;
  - event_ready=0 while rst=1.
- Reset mid-window discards the window with no trigger.
- Forwarding latency: an event accepted in cycle N appears with out_valid=1 in cycle N+1. out_valid is a single-cycle pulse.
- Downstream must consume out_valid regardless of out_ready. out_ready gates only future acceptance.
- Closing event accepted in cycle N:
  - out_valid for that event and compute_trigger both occur in N+1;
  - the downstream must include that event in the window it computes.
- event_ready=0 in N+1 (CLOSE), so there is one bubble per window. The next acceptance can occur in N+2.
- Timestamp wrap: the span uses modular subtraction, so start 0xFFF0 and event 0x0010 give a span of 0x20.
- Simultaneous count_hit and time_hit: a single trigger with window_cause=2'b11.
- Sustained throughput: one event per cycle within a window.

## Test plan
- Count mode: mode=0, threshold=4, 8 back-to-back ON events → triggers in the cycles after the 4th and 8th acceptance, each with count=4 and cause=01. event_ready=0 in both trigger cycles.
- Time mode with wrap: mode=1, cfg_window_ts=0x20, events at ts 0xFFF0, 0x0000, 0x0010 → one trigger after the third event, with span=0x20, count=3, cause=10.
- Polarity filter: mask=2'b10, alternating ON/OFF events, threshold=3 → OFF events accepted but never forwarded. The trigger follows the 3rd ON event with count=3.
- Either-first simultaneous: mode=2, threshold=2, ts window=5, events at ts 0 and 5 → single trigger with cause=11.
- Backpressure and mode 3: out_ready=0 for 3 cycles → event_ready=0 and nothing accepted. Then mode=3 with 10 events → 10 out_valid pulses and no trigger.
- Reset mid-window: mode=0, threshold=5, 3 events, rst pulse, 5 events → exactly one trigger, with count=5 and all outputs 0 during reset.

Source files
------------

// File: rtl/dvs_window_controller.sv
// Purpose : DVS event-windowing front end (count / time / either-first / off) with polarity filter and stats.
// Latency : accepted event forwarded 1 cycle later; window-close trigger in the same cycle as its closing event's forward.
// Backpress: event_ready = out_ready & not-closing & !rst; out_valid must be consumed unconditionally, one bubble per window.
//
// Ports: clk/rst (sync, active-high); cfg_* live configuration; event_* ready/valid input stream;
//        out_* registered forwarded event (single-cycle out_valid); compute_trigger one-cycle close pulse
//        with window_count / window_span / window_cause holding the statistics of the last closed window.
module dvs_window_controller #(
    parameter int X_BITS   = 7,
    parameter int Y_BITS   = 7,
    parameter int TS_BITS  = 16,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_BITS-1:0] cfg_window_events,
    input  logic [TS_BITS-1:0]  cfg_window_ts,
    input  logic [1:0]          cfg_pol_mask,
    input  logic                event_valid,
    output logic                event_ready,
    input  logic [X_BITS-1:0]   event_x,
    input  logic [Y_BITS-1:0]   event_y,
    input  logic                event_polarity,
    input  logic [TS_BITS-1:0]  event_ts,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [X_BITS-1:0]   out_x,
    output logic [Y_BITS-1:0]   out_y,
    output logic                out_polarity,
    output logic [TS_BITS-1:0]  out_ts,
    output logic                compute_trigger,
    output logic [CNT_BITS-1:0] window_count,
    output logic [TS_BITS-1:0]  window_span,
    output logic [1:0]          window_cause
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_COUNT = 2'd0;
    localparam logic [1:0] MODE_TIME  = 2'd1;
    localparam logic [1:0] MODE_EITHER = 2'd2;
    localparam logic [1:0] MODE_OFF   = 2'd3;

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic [TS_BITS-1:0]  start_q, start_d;

    logic                accept;
    logic                counted;
    logic [CNT_BITS-1:0] count_new;
    logic [CNT_BITS-1:0] thresh;
    logic [TS_BITS-1:0]  base_ts;
    logic [TS_BITS-1:0]  span_new;
    logic                count_hit;
    logic                time_hit;
    logic                close_now;

    // The CLOSE cycle refuses input so the trigger cycle never overlaps a new window's first event.
    assign event_ready     = out_ready & (state_q != CLOSE) & ~rst;
    assign accept          = event_valid & event_ready;
    assign counted         = accept & cfg_pol_mask[event_polarity];
    assign compute_trigger = (state_q == CLOSE) & ~rst;

    // Close test for the event being counted this cycle. In IDLE the event opens the window,
    // so its own timestamp is the window start and the span is zero.
    always_comb begin
        count_new = (state_q == OPEN) ? (count_q + CNT_BITS'(1)) : CNT_BITS'(1);
        base_ts   = (state_q == OPEN) ? start_q : event_ts;
        span_new  = event_ts - base_ts;   // modular: wraps naturally across 2^TS_BITS
        thresh    = (cfg_window_events == '0) ? CNT_BITS'(1) : cfg_window_events;

        count_hit = 1'b0;
        if ((cfg_mode == MODE_COUNT) || (cfg_mode == MODE_EITHER)) begin
            count_hit = (count_new >= thresh);
        end else if (cfg_mode == MODE_TIME) begin
            // Time-only windows still must not let the counter wrap.
            count_hit = &count_new;
        end

        time_hit = ((cfg_mode == MODE_TIME) || (cfg_mode == MODE_EITHER)) &&
                   (span_new >= cfg_window_ts);

        close_now = counted && (cfg_mode != MODE_OFF) && (count_hit || time_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            start_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        start_d = start_q;
        case (state_q)
            IDLE: begin
                if (counted && (cfg_mode != MODE_OFF)) begin
                    start_d = event_ts;
                    count_d = count_new;
                    state_d = close_now ? CLOSE : OPEN;
                end
            end
            OPEN: begin
                if (counted) begin
                    count_d = count_new;
                    state_d = close_now ? CLOSE : OPEN;
                end
            end
            CLOSE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (close_now) begin
            count_d = '0;
        end
        // Disabled mode abandons any open window; the trigger of a window already in CLOSE still fires.
        if (cfg_mode == MODE_OFF) begin
            state_d = IDLE;
            count_d = '0;
        end
    end

    // Forwarding and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_x        <= '0;
            out_y        <= '0;
            out_polarity <= 1'b0;
            out_ts       <= '0;
            window_count <= '0;
            window_span  <= '0;
            window_cause <= 2'b00;
        end else begin
            out_valid <= counted;
            if (counted) begin
                out_x        <= event_x;
                out_y        <= event_y;
                out_polarity <= event_polarity;
                out_ts       <= event_ts;
            end
            if (close_now) begin
                window_count <= count_new;
                window_span  <= span_new;
                window_cause <= {time_hit, count_hit};
            end
        end
    end

endmodule

// File: tb/tb_dvs_window_controller.sv
// Purpose : self-checking bench for dvs_window_controller (directed table, hand sequences, random vs reference model).
// Latency : one stimulus step per clock; outputs sampled 1 time unit after the rising edge.
// Backpress: out_ready driven by the bench; every wait is a fixed number of cycles.
module tb_dvs_window_controller;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_window_events;
    logic [15:0] cfg_window_ts;
    logic [1:0]  cfg_pol_mask;
    logic        event_valid;
    logic        event_ready;
    logic [6:0]  event_x;
    logic [6:0]  event_y;
    logic        event_polarity;
    logic [15:0] event_ts;
    logic        out_ready;
    logic        out_valid;
    logic [6:0]  out_x;
    logic [6:0]  out_y;
    logic        out_polarity;
    logic [15:0] out_ts;
    logic        compute_trigger;
    logic [15:0] window_count;
    logic [15:0] window_span;
    logic [1:0]  window_cause;

    dvs_window_controller #(
        .X_BITS(7), .Y_BITS(7), .TS_BITS(16), .CNT_BITS(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_mode(cfg_mode), .cfg_window_events(cfg_window_events),
        .cfg_window_ts(cfg_window_ts), .cfg_pol_mask(cfg_pol_mask),
        .event_valid(event_valid), .event_ready(event_ready),
        .event_x(event_x), .event_y(event_y),
        .event_polarity(event_polarity), .event_ts(event_ts),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_x(out_x), .out_y(out_y), .out_polarity(out_polarity), .out_ts(out_ts),
        .compute_trigger(compute_trigger), .window_count(window_count),
        .window_span(window_span), .window_cause(window_cause)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_trig = 0;
    int n_ov   = 0;
    logic rdy_seen = 1'b0;

    // Reference model: a window is "open" with a count and start timestamp; a close leaves one pending cycle.
    logic m_open  = 1'b0;
    logic m_close = 1'b0;
    int   m_cnt   = 0;
    int   m_start = 0;
    int   e_ov = 0, e_x = 0, e_y = 0, e_pol = 0, e_ts = 0;
    int   e_trig = 0, e_cnt = 0, e_span = 0, e_cause = 0;

    typedef struct {
        logic       valid;
        logic       exp_ready;
        logic       exp_ov;
        logic       exp_trig;
        int         exp_cnt;
        int         exp_cause;
    } vec_t;
    vec_t tab[10];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check combinational ready, advance the model, clock, then check registered outputs.
    task automatic cyc();
        logic exp_rdy, acc, cnt_ev, ch, th;
        int   span, thr;
        #1;
        exp_rdy  = out_ready && !m_close && !rst;
        rdy_seen = event_ready;
        chk("event_ready", int'(event_ready), int'(exp_rdy));
        acc    = event_valid && exp_rdy;
        cnt_ev = acc && cfg_pol_mask[event_polarity];
        e_trig = 0;
        if (rst) begin
            e_ov = 0; e_x = 0; e_y = 0; e_pol = 0; e_ts = 0;
            e_cnt = 0; e_span = 0; e_cause = 0;
            m_open = 1'b0; m_cnt = 0;
        end else begin
            e_ov = int'(cnt_ev);
            if (cnt_ev) begin
                e_x = int'(event_x); e_y = int'(event_y);
                e_pol = int'(event_polarity); e_ts = int'(event_ts);
            end
            if (cfg_mode == 2'd3) begin
                m_open = 1'b0; m_cnt = 0;
            end else if (cnt_ev) begin
                if (!m_open) begin
                    m_start = int'(event_ts);
                    m_cnt   = 0;
                end
                m_cnt++;
                span = (int'(event_ts) - m_start + 65536) % 65536;
                thr  = (cfg_window_events == 16'd0) ? 1 : int'(cfg_window_events);
                ch   = (cfg_mode != 2'd1) ? (m_cnt >= thr) : (m_cnt == 65535);
                th   = (cfg_mode != 2'd0) && (span >= int'(cfg_window_ts));
                if (ch || th) begin
                    e_trig = 1; e_cnt = m_cnt; e_span = span; e_cause = int'({th, ch});
                    m_open = 1'b0; m_cnt = 0;
                end else begin
                    m_open = 1'b1;
                end
            end
        end
        m_close = (e_trig != 0);
        @(posedge clk);
        #1;
        chk("out_valid", int'(out_valid), e_ov);
        chk("compute_trigger", int'(compute_trigger), e_trig);
        chk("window_count", int'(window_count), e_cnt);
        chk("window_span", int'(window_span), e_span);
        chk("window_cause", int'(window_cause), e_cause);
        chk("out_x", int'(out_x), e_x);
        chk("out_y", int'(out_y), e_y);
        chk("out_polarity", int'(out_polarity), e_pol);
        chk("out_ts", int'(out_ts), e_ts);
        if (compute_trigger) n_trig++;
        if (out_valid) n_ov++;
    endtask

    task automatic send(input logic pol, input logic [15:0] ts);
        event_valid    = 1'b1;
        event_polarity = pol;
        event_ts       = ts;
        event_x        = event_x + 7'd3;
        event_y        = event_y + 7'd5;
        cyc();
    endtask

    task automatic idle_cycle();
        event_valid = 1'b0;
        cyc();
    endtask

    initial begin
        int t0, o0;
        logic [15:0] ts;

        rst = 1'b1; cfg_mode = 2'd0; cfg_window_events = 16'd4; cfg_window_ts = 16'd0;
        cfg_pol_mask = 2'b11; event_valid = 1'b0; event_x = 7'd1; event_y = 7'd2;
        event_polarity = 1'b1; event_ts = 16'd0; out_ready = 1'b1;
        cyc();
        cyc();
        chk("reset_ready", int'(rdy_seen), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_trigger", int'(compute_trigger), 0);
        chk("reset_window_count", int'(window_count), 0);
        rst = 1'b0;

        // Count mode, threshold 4, back-to-back ON events.
        tab[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
        tab[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
        tab[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
        tab[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 4, 1};
        tab[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
        tab[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
        tab[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
        tab[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
        tab[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 4, 1};
        tab[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
        cfg_mode = 2'd0; cfg_window_events = 16'd4;
        for (int i = 0; i < 10; i++) begin
            event_valid    = tab[i].valid;
            event_polarity = 1'b1;
            event_ts       = 16'h0100 + 16'(i);
            event_x        = 7'(i + 10);
            cyc();
            chk("tab_ready", int'(rdy_seen), int'(tab[i].exp_ready));
            chk("tab_out_valid", int'(out_valid), int'(tab[i].exp_ov));
            chk("tab_trigger", int'(compute_trigger), int'(tab[i].exp_trig));
            if (tab[i].exp_trig) begin
                chk("tab_count", int'(window_count), tab[i].exp_cnt);
                chk("tab_cause", int'(window_cause), tab[i].exp_cause);
            end
        end
        idle_cycle();

        // Time mode across timestamp wrap.
        cfg_mode = 2'd1; cfg_window_ts = 16'h0020;
        send(1'b1, 16'hFFF0);
        chk("wrap_no_trig1", int'(compute_trigger), 0);
        send(1'b0, 16'h0000);
        chk("wrap_no_trig2", int'(compute_trigger), 0);
        send(1'b1, 16'h0010);
        chk("wrap_trig", int'(compute_trigger), 1);
        chk("wrap_span", int'(window_span), 32);
        chk("wrap_count", int'(window_count), 3);
        chk("wrap_cause", int'(window_cause), 2);
        idle_cycle();

        // Polarity filter: only ON events count and forward.
        cfg_mode = 2'd0; cfg_window_events = 16'd3; cfg_pol_mask = 2'b10;
        t0 = n_trig; o0 = n_ov;
        for (int i = 0; i < 5; i++) begin
            send((i % 2) == 0, 16'(200 + i));
            if (i == 4) begin
                chk("pol_trig", int'(compute_trigger), 1);
                chk("pol_count", int'(window_count), 3);
            end
        end
        idle_cycle();
        chk("pol_forwarded", n_ov - o0, 3);
        chk("pol_triggers", n_trig - t0, 1);

        // Either-first with both thresholds hit by the same event.
        cfg_mode = 2'd2; cfg_window_events = 16'd2; cfg_window_ts = 16'd5; cfg_pol_mask = 2'b11;
        t0 = n_trig;
        send(1'b1, 16'd0);
        send(1'b0, 16'd5);
        chk("either_cause", int'(window_cause), 3);
        chk("either_span", int'(window_span), 5);
        idle_cycle();
        chk("either_triggers", n_trig - t0, 1);

        // Backpressure, then disabled mode forwarding.
        out_ready = 1'b0; o0 = n_ov;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 16'(300 + i));
            chk("bp_ready", int'(rdy_seen), 0);
        end
        chk("bp_no_forward", n_ov - o0, 0);
        out_ready = 1'b1; cfg_mode = 2'd3; cfg_window_events = 16'd1;
        t0 = n_trig; o0 = n_ov;
        for (int i = 0; i < 10; i++) send(i[0], 16'(400 + i));
        idle_cycle();
        chk("off_forwarded", n_ov - o0, 10);
        chk("off_triggers", n_trig - t0, 0);

        // Reset in the middle of a window discards it.
        cfg_mode = 2'd0; cfg_window_events = 16'd5;
        for (int i = 0; i < 3; i++) send(1'b1, 16'(500 + i));
        rst = 1'b1; event_valid = 1'b0;
        cyc();
        chk("rst_ready", int'(rdy_seen), 0);
        chk("rst_out_x", int'(out_x), 0);
        chk("rst_out_ts", int'(out_ts), 0);
        chk("rst_window_count", int'(window_count), 0);
        chk("rst_window_span", int'(window_span), 0);
        chk("rst_window_cause", int'(window_cause), 0);
        rst = 1'b0;
        t0 = n_trig;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 16'(600 + i));
            if (i < 4) chk("rst_no_early_trig", int'(compute_trigger), 0);
        end
        chk("rst_count5", int'(window_count), 5);
        idle_cycle();
        chk("rst_triggers", n_trig - t0, 1);

        // Randomized traffic against the reference model, including live config changes and wrap.
        ts = 16'hFF00;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                cfg_mode          = 2'($urandom_range(0, 3));
                cfg_window_events = 16'($urandom_range(0, 6));
                cfg_window_ts     = 16'($urandom_range(0, 40));
                cfg_pol_mask      = 2'($urandom_range(0, 3));
            end
            rst            = ($urandom_range(0, 299) == 0);
            out_ready      = ($urandom_range(0, 7) != 0);
            event_valid    = ($urandom_range(0, 3) != 0);
            event_polarity = 1'($urandom_range(0, 1));
            event_x        = 7'($urandom_range(0, 127));
            event_y        = 7'($urandom_range(0, 127));
            ts             = ts + 16'($urandom_range(0, 6));
            event_ts       = ts;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
